// File: rtl/spi_frame_host_if.sv
// Host-side bundle for spi_frame_host: command inputs, SPI pins and capture stream.
// master = the SPI host block, slave = bridge logic plus probe pins.
interface spi_frame_host_if;
  logic        start;
  logic        resync;
  logic [1:0]  width_cfg;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        busy;
  logic        hdr_valid;
  logic        hdr_empty;
  logic [1:0]  hdr_width;
  logic        hdr_sync;
  logic        hdr_error;
  logic        word_valid;
  logic [15:0] word_data;
  logic [2:0]  word_index;
  logic        frame_done;

  modport master (
    input  start, resync, width_cfg, miso,
    output sck, mosi, busy, hdr_valid, hdr_empty, hdr_width, hdr_sync, hdr_error,
           word_valid, word_data, word_index, frame_done
  );

  modport slave (
    output start, resync, width_cfg, miso,
    input  sck, mosi, busy, hdr_valid, hdr_empty, hdr_width, hdr_sync, hdr_error,
           word_valid, word_data, word_index, frame_done
  );
endinterface

// File: rtl/spi_frame_host.sv
// SPI host for the trace-probe link: sends a command byte, captures an 8-bit header
// and eight byte-swapped 16-bit words, and reports them as valid pulses.
module spi_frame_host #(
  parameter int CLK_DIV = 2
) (
  input logic             clk,
  input logic             rst,
  spi_frame_host_if.master bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_HDR, S_DATA, S_DONE} state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [6:0]    bit_q;
  logic [7:0]    cmd_q;
  logic          resync_q;
  logic          last_q;
  logic [15:0]   shift_q;
  logic          hdr_pend_q;
  logic          word_pend_q;
  logic [2:0]    word_num_q;
  logic          sck_q, mosi_q, busy_q;
  logic          hdr_valid_q, hdr_empty_q, hdr_sync_q, hdr_error_q;
  logic [1:0]    hdr_width_q;
  logic          word_valid_q, frame_done_q;
  logic [15:0]   word_data_q;
  logic [2:0]    word_index_q;
  logic [15:0]   rx_d;

  assign rx_d = {shift_q[14:0], bus.miso};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      cmd_q        <= '0;
      resync_q     <= 1'b0;
      last_q       <= 1'b0;
      shift_q      <= '0;
      hdr_pend_q   <= 1'b0;
      word_pend_q  <= 1'b0;
      word_num_q   <= '0;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      hdr_valid_q  <= 1'b0;
      hdr_empty_q  <= 1'b0;
      hdr_width_q  <= '0;
      hdr_sync_q   <= 1'b0;
      hdr_error_q  <= 1'b0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_index_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hdr_valid_q  <= 1'b0;
      word_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      hdr_pend_q   <= 1'b0;
      word_pend_q  <= 1'b0;

      // Captures complete on a falling edge; publish them one clk later.
      if (hdr_pend_q) begin
        hdr_valid_q <= 1'b1;
        hdr_empty_q <= shift_q[7];
        hdr_width_q <= shift_q[2:1];
        hdr_sync_q  <= shift_q[0];
        hdr_error_q <= |shift_q[6:3];
      end
      if (word_pend_q) begin
        word_valid_q <= ~hdr_empty_q;
        word_data_q  <= {shift_q[7:0], shift_q[15:8]};
        word_index_q <= word_num_q;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.resync || bus.start) begin
            state_q  <= S_CMD;
            busy_q   <= 1'b1;
            div_q    <= '0;
            bit_q    <= '0;
            last_q   <= 1'b0;
            resync_q <= bus.resync;
            cmd_q    <= bus.resync ? 8'hA5 : {4'hA, bus.width_cfg, 2'b00};
          end
        end
        S_CMD, S_HDR, S_DATA: begin
          if (div_q != '0) begin
            div_q <= div_q - DW'(1);
          end else if (!sck_q) begin
            if (last_q) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
              mosi_q       <= 1'b0;
            end else begin
              sck_q  <= 1'b1;
              div_q  <= DIV_LOAD;
              mosi_q <= (state_q == S_CMD) & cmd_q[7];
              cmd_q  <= {cmd_q[6:0], 1'b0};
            end
          end else begin
            sck_q   <= 1'b0;
            div_q   <= DIV_LOAD;
            shift_q <= rx_d;
            bit_q   <= bit_q + 7'd1;
            if (state_q == S_CMD) begin
              if (bit_q == 7'd7) begin
                bit_q <= '0;
                if (resync_q) last_q <= 1'b1;
                else          state_q <= S_HDR;
              end
            end else if (state_q == S_HDR) begin
              if (bit_q == 7'd7) begin
                bit_q      <= '0;
                state_q    <= S_DATA;
                hdr_pend_q <= 1'b1;
              end
            end else begin
              if (bit_q[3:0] == 4'hF) begin
                word_pend_q <= 1'b1;
                word_num_q  <= bit_q[6:4];
              end
              if (bit_q == 7'd127) last_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q      <= S_IDLE;
          word_index_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.sck        = sck_q;
  assign bus.mosi       = mosi_q;
  assign bus.busy       = busy_q;
  assign bus.hdr_valid  = hdr_valid_q;
  assign bus.hdr_empty  = hdr_empty_q;
  assign bus.hdr_width  = hdr_width_q;
  assign bus.hdr_sync   = hdr_sync_q;
  assign bus.hdr_error  = hdr_error_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign bus.word_index = word_index_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/spi_frame_host.md
# spi_frame_host

SPI master that drives the trace-probe serial link from the host end of the probe link. It clocks out one command byte, then captures the probe's returned frame: an 8-bit header and eight 16-bit trace words. Captured words are restored to their original byte order and presented on a valid-pulse stream. The block sits between the host-side bridge logic and the probe's SPI pins, and owns SCK generation, command encoding, frame capture and header checking.

## Interface
- CLK_DIV, 2: clk cycles per SCK half-period (≥1).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request one frame transaction; sampled only in IDLE.
- resync  in  1  request an 8-bit 0xA5 resync transaction; sampled only in IDLE.
- width_cfg  in  2  probe pin-width code placed in the command byte (0→1, 1→2, 3→4 pins; 2 reserved, sent as-is).
- sck  out  1  SPI clock; idles low.
- mosi  out  1  command bits, MSB first.
- miso  in  1  probe data; already synchronous to clk.
- busy  out  1  high from the accepting edge until return to IDLE.
- hdr_valid  out  1  one-cycle pulse when the header is captured.
- hdr_empty  out  1  header bit 7: frame carries no data.
- hdr_width  out  2  header bits 2:1: width echoed by the probe.
- hdr_sync  out  1  header bit 0.
- hdr_error  out  1  header bits 6:3 non-zero; held until the next header.
- word_valid  out  1  one-cycle pulse per captured data word.
- word_data  out  16  captured word, byte-swapped back: {second byte, first byte} = original {hi, lo}.
- word_index  out  3  0..7, index of word_data within the frame.
- frame_done  out  1  one-cycle pulse at the end of each frame or resync transaction.

## Operation
- States: IDLE, CMD, HDR, DATA, DONE.
- IDLE → CMD when `resync` or `start` is seen. If both are high, `resync` wins and `start` is dropped. The command byte is latched at this point:
  - resync: 0xA5.
  - start: {4'hA, width_cfg, 2'b00}.
- CMD: 8 SCK periods carrying the command byte.
  - After a resync command, go to DONE.
  - After a start command, go to HDR.
- HDR: 8 SCK periods. `mosi` = 0. MISO is shifted MSB-first into the header register. At the end of HDR, latch the `hdr_*` outputs and pulse `hdr_valid`.
- DATA: 128 SCK periods (8 words × 16 bits). `mosi` = 0.
  - Each word arrives as its low byte first, then its high byte, each byte MSB first.
  - `word_data` = {bits 7:0 received, bits 15:8 received}, i.e. the second received byte goes to [15:8].
  - `word_valid` pulses after each 16th bit only if `hdr_empty`=0. Zero words are still clocked through.
  - `word_index` counts 0..7 and wraps to 0 at frame end.
- DONE: pulse `frame_done` for one cycle, then return to IDLE.
- `start`/`resync` asserted while `busy` are ignored, not queued.
- Width code 2 is transmitted unchanged. The block does not check `hdr_width` against `width_cfg`.

## Timing
- SCK period = 2·CLK_DIV clk cycles, phased as follows:
  - Rising edge starts each period; `mosi` changes on the same clk edge that raises `sck`.
  - `sck` stays high for CLK_DIV cycles.
  - The falling edge is where the probe samples `mosi` and the host samples `miso`. The host samples `miso` on the clk edge that drives `sck` low.
  - `sck` stays low for CLK_DIV cycles.
- First `sck` rise occurs on the clk edge after the accepting edge. `busy` rises on the accepting edge.
- Frame transaction: 144 SCK periods. `frame_done` follows the last falling edge by CLK_DIV cycles (low phase completes), and `busy` drops with `frame_done`. Total busy time for a frame = 288·CLK_DIV + 1 cycles.
- Resync transaction: 8 SCK periods, busy time 16·CLK_DIV + 1 cycles.
- `hdr_valid` is on the clk edge after the 16th falling edge. `word_valid` for word k is on the clk edge after falling edge 16+16(k+1).
- Reset values: sck=0, mosi=0, busy=0, all pulses 0, `hdr_*`=0, `word_data`=0, `word_index`=0, state IDLE.
- Reset mid-transaction: outputs return to their reset values immediately. The partial word or header is discarded and no pulse is emitted. The probe-side bit alignment is then undefined, so the host must issue `resync` before the next `start`.

## Test plan
- Reset, then CLK_DIV=2, width_cfg=3, start pulse: mosi bits on falling edges = 1,0,1,0,1,1,0,0 (0xAC); busy lasts 577 cycles; one frame_done.
- Probe model returns header 0x05 and words 0x1234..0x123B sent low-byte-first: hdr_valid with empty=0, width=2, sync=1, error=0; eight word_valid with word_data=0x1234..0x123B and word_index 0..7.
- Probe header 0x80 (empty): hdr_empty=1, no word_valid, frame_done still after 144 SCK periods.
- Header 0x48: hdr_error=1. Next frame with header 0x06: error clears.
- resync and start asserted together: mosi carries 0xA5, 8 SCK periods only, frame_done at busy time 33 cycles (CLK_DIV=2), start dropped.
- rst asserted at SCK period 70: sck=mosi=busy=0 immediately, no word_valid. A subsequent start runs a full 144-period frame.
